// File: rtl/cga_mode_programmer.sv
// ISA I/O-write initiator that loads CRTC, mode-control and colour-select registers for one of four CGA modes.
// Optional CGA_MODE_BLANK_FIRST_EN prepends a video-disabled mode-control write so the CRTC is reprogrammed blanked.
module cga_mode_programmer #(
    parameter logic [15:0] IO_BASE_ADDR = 16'h3d0,
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned STROBE_CYC   = 3,
    parameter int unsigned HOLD_CYC     = 1
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        start,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        done,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [14:0] bus_a,
    output logic [7:0]  bus_d,
    output logic        bus_iow_l,
    output logic        bus_aen
);
    localparam int unsigned IDX_W = 6;
    localparam int unsigned CNT_W = 8;
`ifdef CGA_MODE_BLANK_FIRST_EN
    localparam int unsigned PRE = 1;
`else
    localparam int unsigned PRE = 0;
`endif
    localparam int unsigned LAST = 33 + PRE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    function automatic logic [7:0] crtc_val(input logic [1:0] m, input logic [3:0] r);
        logic       gfx;
        logic       hi;
        logic [7:0] v;
        gfx = m[1];
        hi  = (m == 2'd1);
        case (r)
            4'd0:    v = hi  ? 8'h71 : 8'h38;
            4'd1:    v = hi  ? 8'h50 : 8'h28;
            4'd2:    v = hi  ? 8'h5a : 8'h2d;
            4'd3:    v = 8'h0a;
            4'd4:    v = gfx ? 8'h7f : 8'h1f;
            4'd5:    v = 8'h06;
            4'd6:    v = gfx ? 8'h64 : 8'h19;
            4'd7:    v = gfx ? 8'h70 : 8'h1c;
            4'd8:    v = 8'h02;
            4'd9:    v = gfx ? 8'h01 : 8'h07;
            4'd10:   v = 8'h06;
            4'd11:   v = 8'h07;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] mode_val(input logic [1:0] m);
        logic [7:0] v;
        case (m)
            2'd0:    v = 8'h28;
            2'd1:    v = 8'h29;
            2'd2:    v = 8'h2a;
            default: v = 8'h1e;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] color_val(input logic [1:0] m);
        return (m == 2'd3) ? 8'h3f : 8'h30;
    endfunction

    // Address/data for write slot idx: {addr[14:0], data[7:0]}.
    function automatic logic [22:0] wr_word(input logic [IDX_W-1:0] idx, input logic [1:0] m);
        logic [IDX_W-1:0] s;
        logic [14:0]      a;
        logic [7:0]       d;
        s = idx - IDX_W'(PRE);
        if (PRE != 0 && idx == '0) begin
            a = 15'(IO_BASE_ADDR + 16'd8);
            d = mode_val(m) & 8'hf7;
        end else if (s < IDX_W'(32)) begin
            if (s[0]) begin
                a = 15'(IO_BASE_ADDR + 16'd5);
                d = crtc_val(m, s[4:1]);
            end else begin
                a = 15'(IO_BASE_ADDR + 16'd4);
                d = {4'h0, s[4:1]};
            end
        end else if (s == IDX_W'(32)) begin
            a = 15'(IO_BASE_ADDR + 16'd8);
            d = mode_val(m);
        end else begin
            a = 15'(IO_BASE_ADDR + 16'd9);
            d = color_val(m);
        end
        return {a, d};
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             req_q, req_d;
    logic             iow_l_q, iow_l_d;
    logic [14:0]      a_q, a_d;
    logic [7:0]       dat_q, dat_d;
    logic [22:0]      word;
    logic             drive;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            iow_l_q <= 1'b1;
            a_q     <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            req_q   <= req_d;
            iow_l_q <= iow_l_d;
            a_q     <= a_d;
            dat_q   <= dat_d;
        end
    end

    // Outputs are registered from the next state, so they line up with state_q.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    idx_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == CNT_W'(STROBE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                // The NEXT decision is taken on the last hold clock so writes stay back-to-back.
                if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                    cnt_d = '0;
                    if (idx_q == IDX_W'(LAST)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = bus_gnt ? S_SETUP : S_REQ;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        word    = wr_word(idx_d, mode_d);
        drive   = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        a_d     = drive ? word[22:8] : '0;
        dat_d   = drive ? word[7:0] : '0;
        iow_l_d = (state_d != S_STROBE);
        req_d   = drive || (state_d == S_REQ);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign bus_req   = req_q;
    assign bus_iow_l = iow_l_q;
    assign bus_a     = a_q;
    assign bus_d     = dat_q;
    assign bus_aen   = 1'b0;
endmodule

// File: tb/tb_cga_mode_programmer.sv
// Scoreboard bench for cga_mode_programmer: expected writes queued at start, popped on each iow falling edge.
module tb_cga_mode_programmer;
`ifdef CGA_MODE_BLANK_FIRST_EN
    localparam int NW = 35;
`else
    localparam int NW = 34;
`endif

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        bus_gnt = 1'b1;
    logic        busy, done, bus_req, bus_iow_l, bus_aen;
    logic [14:0] bus_a;
    logic [7:0]  bus_d;

    cga_mode_programmer dut (
        .clk(clk), .reset_l(reset_l), .start(start), .mode(mode),
        .busy(busy), .done(done), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .bus_a(bus_a), .bus_d(bus_d), .bus_iow_l(bus_iow_l), .bus_aen(bus_aen)
    );

    always #5 clk = ~clk;

    logic [7:0] crtc_t [4][16] = '{
        '{8'h38,8'h28,8'h2d,8'h0a,8'h1f,8'h06,8'h19,8'h1c,8'h02,8'h07,8'h06,8'h07,8'h00,8'h00,8'h00,8'h00},
        '{8'h71,8'h50,8'h5a,8'h0a,8'h1f,8'h06,8'h19,8'h1c,8'h02,8'h07,8'h06,8'h07,8'h00,8'h00,8'h00,8'h00},
        '{8'h38,8'h28,8'h2d,8'h0a,8'h7f,8'h06,8'h64,8'h70,8'h02,8'h01,8'h06,8'h07,8'h00,8'h00,8'h00,8'h00},
        '{8'h38,8'h28,8'h2d,8'h0a,8'h7f,8'h06,8'h64,8'h70,8'h02,8'h01,8'h06,8'h07,8'h00,8'h00,8'h00,8'h00}
    };
    logic [7:0] mode_t  [4] = '{8'h28, 8'h29, 8'h2a, 8'h1e};
    logic [7:0] color_t [4] = '{8'h30, 8'h30, 8'h30, 8'h3f};

    logic [22:0] sb[$];
    int total = 0, bad = 0;
    int cyc = 0, strobes = 0, low_len = 0, done_cnt = 0, done_cyc = 0, first_cyc = 0;
    int strobe_base = 0, done_base = 0;
    bit prev_iow = 1'b1, skip_len = 1'b0, arm_first = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard pop per strobe, strobe width, done pulses and latency markers.
    always @(negedge clk) begin
        logic [22:0] e;
        cyc++;
        if (!reset_l) skip_len = 1'b1;
        if (!bus_iow_l && prev_iow) begin
            strobes++;
            low_len  = 1;
            skip_len = 1'b0;
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'({bus_a, bus_d}), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("write_addr_data", 32'({bus_a, bus_d}), 32'(e));
            end
        end else if (!bus_iow_l) begin
            low_len++;
        end else if (!prev_iow) begin
            if (!skip_len) chk("strobe_len", 32'(low_len), 32'(3));
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (arm_first && bus_a != 15'h0) begin
            first_cyc = cyc;
            arm_first = 1'b0;
        end
        prev_iow = bus_iow_l;
    end

    task automatic push_seq(input logic [1:0] m);
`ifdef CGA_MODE_BLANK_FIRST_EN
        sb.push_back({15'h3d8, mode_t[m] & 8'hf7});
`endif
        for (int k = 0; k < 16; k++) begin
            sb.push_back({15'h3d4, 8'(k)});
            sb.push_back({15'h3d5, crtc_t[m][k]});
        end
        sb.push_back({15'h3d8, mode_t[m]});
        sb.push_back({15'h3d9, color_t[m]});
    endtask

    task automatic start_seq(input logic [1:0] m);
        strobe_base = strobes;
        done_base   = done_cnt;
        push_seq(m);
        arm_first = 1'b1;
        @(posedge clk); #1 mode = m; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; mode = ~m;
        @(negedge clk);
        chk("busy_on_start", 32'(busy), 32'(1));
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n = 0;
        while (strobes < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("strobe_wait", 32'(strobes >= target), 32'(1));
    endtask

    task automatic finish_seq(input bit timing);
        int n = 0;
        while (done_cnt == done_base && n < 600) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_seen", 32'(done_cnt != done_base), 32'(1));
        chk("write_count", 32'(strobes - strobe_base), 32'(NW));
        chk("sb_empty", 32'(sb.size()), 32'(0));
        if (timing) chk("done_latency", 32'(done_cyc - first_cyc), 32'(NW * 6));
        repeat (3) @(negedge clk);
        chk("done_pulses", 32'(done_cnt - done_base), 32'(1));
        chk("busy_after", 32'({busy, bus_req, bus_iow_l, bus_a}), 32'({1'b0, 1'b0, 1'b1, 15'h0}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held while start toggles.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 start = ~start;
            @(negedge clk);
            chk("reset_state", 32'({busy, done, bus_req, bus_iow_l, bus_aen, bus_a, bus_d}),
                32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 15'h0, 8'h0}));
        end
        @(posedge clk); #1 start = 1'b0; reset_l = 1'b1;
        repeat (2) @(posedge clk);

        // Mode 1, grant tied high.
        start_seq(2'd1);
        finish_seq(1'b1);

        // Mode 2, grant dropped during strobe of write 5.
        start_seq(2'd2);
        wait_strobes(strobe_base + 6, 300);
        @(posedge clk); #1 bus_gnt = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("no_grant_idle", 32'({bus_iow_l, bus_req, busy, bus_a, bus_d}),
                32'({1'b1, 1'b1, 1'b1, 15'h0, 8'h0}));
        end
        @(posedge clk); #1 bus_gnt = 1'b1;
        finish_seq(1'b0);

        // Mode 0, start re-pulsed during write 10 must be ignored.
        start_seq(2'd0);
        wait_strobes(strobe_base + 11, 300);
        @(posedge clk); #1 mode = 2'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        finish_seq(1'b1);
        repeat (30) @(negedge clk);
        chk("idle_after_ignored_start", 32'({busy, bus_req, bus_iow_l}), 32'(3'b001));

        // Reset during a strobe aborts immediately.
        start_seq(2'd1);
        wait_strobes(strobe_base + 4, 300);
        @(posedge clk); #1 reset_l = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_abort", 32'({bus_iow_l, busy, bus_req, done, bus_a}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 15'h0}));
        sb.delete();
        arm_first = 1'b0;
        @(posedge clk); #1 reset_l = 1'b1;
        repeat (2) @(posedge clk);

        // Mode 3 after the abort.
        start_seq(2'd3);
        finish_seq(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cga_mode_programmer.md
Name: cga_mode_programmer

Overview:
ISA I/O-write initiator that programs the CGA adapter into one of four standard video modes without CPU involvement, for example at boot or when splash mode ends. On a start request it arbitrates for the bus, then issues a fixed sequence of byte-wide I/O writes:
- CRTC index to 3D4 and data to 3D5 for R0-R15.
- Mode control to 3D8.
- Colour select to 3D9.
Its outputs drive the same bus_a/bus_d/bus_iow_l/bus_aen signals the adapter decodes.

Parameters:
IO_BASE_ADDR, 16'h3d0, adapter I/O base; targets are base+4, +5, +8, +9.
SETUP_CYC, 2, clocks address/data are valid before bus_iow_l falls (min 1).
STROBE_CYC, 3, clocks bus_iow_l is held low (min 2, because the adapter synchronises iow through one flop).
HOLD_CYC, 1, clocks address/data are held after bus_iow_l rises (min 1).

Ports:
clk  in  1  system clock; single clock domain
reset_l  in  1  synchronous, active-low reset, sampled on posedge clk
start  in  1  one-clock request; sampled only in IDLE
mode  in  2  0=40x25 text, 1=80x25 text, 2=320x200 gfx, 3=640x200 gfx; latched on accepted start
busy  out  1  high from accepted start until DONE exits
done  out  1  one-clock pulse after the last write's hold phase
bus_req  out  1  bus request to the arbiter
bus_gnt  in  1  bus grant from the arbiter
bus_a  out  15  I/O address; 0 when not owning the bus
bus_d  out  8  write data; 0 when not owning the bus
bus_iow_l  out  1  I/O write strobe, active low
bus_aen  out  1  held at 0 (I/O decode enabled) by this block

Behaviour:
- Reset (reset_l=0 at posedge): state=IDLE; busy=0, done=0, bus_req=0, bus_iow_l=1, bus_a=0, bus_d=0, bus_aen=0; write index=0. Reset mid-cycle aborts immediately, and bus_iow_l is 1 on the next clock.
- State machine:
  - IDLE: on start=1, latch mode, clear the index, set busy, go to REQ.
  - REQ: assert bus_req. When bus_gnt=1, drive addr/data for the current index and go to SETUP.
  - SETUP: wait SETUP_CYC clocks, then go to STROBE.
  - STROBE: bus_iow_l=0 for STROBE_CYC clocks, then go to HOLD.
  - HOLD: bus_iow_l=1 for HOLD_CYC clocks, then go to NEXT.
  - NEXT: if index==last, go to DONE; else increment the index. Go to SETUP if bus_gnt=1, otherwise go to REQ.
  - DONE: pulse done for one clock; drop bus_req, busy and bus drive; return to IDLE.
- bus_req stays high from REQ through HOLD of the final write.
- If bus_gnt drops during SETUP/STROBE/HOLD, the current write completes; the loss of grant is honoured at NEXT.
- Each write lasts exactly SETUP_CYC+STROBE_CYC+HOLD_CYC clocks with no extra clocks. The defaults give 6 clocks per write.
- start while busy is ignored and has no queueing.
- Write sequence (index 0..33):
  - Even index 2k (k=0..15): address base+4, data k.
  - Odd index 2k+1: address base+5, data CRTC[mode][k].
  - Index 32: address base+8, data MODE[mode].
  - Index 33: address base+9, data COLOR[mode].
- CRTC tables (R0..R15, hex):
  - mode0: 38 28 2D 0A 1F 06 19 1C 02 07 06 07 00 00 00 00
  - mode1: 71 50 5A 0A 1F 06 19 1C 02 07 06 07 00 00 00 00
  - mode2 and mode3: 38 28 2D 0A 7F 06 64 70 02 01 06 07 00 00 00 00
- MODE per mode: 28, 29, 2A, 1E.
- COLOR per mode: 30, 30, 30, 3F.
- Index counter is 6 bits and never wraps past 33.

Optional Feature:
CGA_MODE_BLANK_FIRST_EN
- Defined: one extra write is prepended. It goes to base+8 with data MODE[mode] & 8'hF7 (video disabled), so the CRTC is reprogrammed while the display is blanked. Total is 35 writes; indices shift by 1 and last=34.
- Undefined: exactly 34 writes as above; last=33.

Test Plan:
1. Reset with reset_l=0 while toggling start for 5 clocks -> busy=0, bus_iow_l=1, bus_req=0, bus_a=0 throughout.
2. start, mode=1, bus_gnt tied 1 -> first write has bus_a=15'h3d4, bus_d=00. Next write is 3d5/71, then 3d5/50 for R1, ending with 3d8/29 and 3d9/30. Total 34 strobes, each exactly 3 clocks low. done pulses once, 204 clocks after the first SETUP.
3. mode=3 -> R4 data 7F, R9 data 01, final writes 3d8/1E and 3d9/3F.
4. Drop bus_gnt during STROBE of write 5 for 20 clocks -> write 5 completes unshortened, then bus_iow_l stays 1 and the bus is undriven until the grant returns. Write 6 (3d4/03) follows, and no write is skipped or duplicated.
5. Pulse start again at write 10 -> ignored, sequence unchanged, single done pulse. Assert reset_l=0 during STROBE -> bus_iow_l=1 and busy=0 on the next clock.
6. With CGA_MODE_BLANK_FIRST_EN, mode=0 -> first write is 3d8/20, total 35 writes, last write 3d9/30.
